// File: rtl/debug_capture_pkg.sv
// rtl/debug_capture_pkg.sv - shared encodings, states and frame constants for debug_capture
package debug_capture_pkg;

    localparam logic [1:0] MODE_CONTINUOUS = 2'd0;
    localparam logic [1:0] MODE_ON_CHANGE  = 2'd1;
    localparam logic [1:0] MODE_SINGLE     = 2'd2;
    localparam logic [1:0] MODE_OFF        = 2'd3;

    localparam logic [3:0]   HDR_TAG      = 4'hA;
    // Wide enough for any sensible DATA_W; sliced down at the use site.
    localparam logic [255:0] TRAILER_WORD = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_HEADER,
        ST_STAMP,
        ST_SAMPLE,
        ST_TRAILER
    } state_t;

endpackage

// File: rtl/debug_sync_fifo.sv
// rtl/debug_sync_fifo.sv - single-clock show-ahead FIFO with a registered read port
module debug_sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH),
    localparam int UW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [UW-1:0]    usedw
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [UW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             w_pop;
    logic [AW-1:0]    w_rd_ptr_next;

    assign w_pop         = rd_en & r_q_valid;
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);

    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[r_wr_ptr] <= wr_data;
    end

    // The head register only sees words already in memory, so a push becomes visible one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            if (wr_en)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr  <= w_rd_ptr_next;
            r_count   <= r_count + UW'(wr_en) - UW'(w_pop);
            r_q_valid <= (r_count != UW'(w_pop));
            r_q       <= (r_count != UW'(w_pop)) ? r_mem[w_rd_ptr_next] : '0;
        end
    end

    assign rd_data  = r_q;
    assign rd_valid = r_q_valid;
    assign usedw    = r_count;

endmodule

// File: rtl/debug_capture.sv
// rtl/debug_capture.sv - multi-channel debug capture packing samples into framed FIFO words
// Optional DEBUG_CAPTURE_TIMESTAMP_EN adds a cycle-counter word after each header.
module debug_capture
    import debug_capture_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  N_CH      = 4,
    parameter int  FRAME_LEN = 512,
    parameter int  DEPTH     = 4096,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             cfg_mode,
    input  logic [CH_W-1:0]        cfg_chan,
    input  logic                   arm,
    input  logic [N_CH*DATA_W-1:0] debug_in,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [15:0]            frames_deferred
);

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    localparam int FRAME_WORDS = FRAME_LEN + 3;
`else
    localparam int FRAME_WORDS = FRAME_LEN + 2;
`endif
    localparam int UW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [CH_W-1:0]    r_chan;
    logic [7:0]         r_seq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_first;
    logic [DATA_W-1:0]  r_last;
    logic               r_deferring;
    logic [15:0]        r_frames_deferred;

    logic               w_wr_en;
    logic [DATA_W-1:0]  w_wr_data;
    logic [DATA_W-1:0]  w_sample;
    logic [DATA_W-1:0]  w_header;
    logic               w_take;
    logic               w_pop;
    logic               w_space_ok;
    logic [UW-1:0]      w_usedw;
    logic [UW-1:0]      w_occ_after;

    assign w_sample    = debug_in[int'(r_chan)*DATA_W +: DATA_W];
    assign w_take      = (r_mode != MODE_ON_CHANGE) || r_first || (w_sample != r_last);
    assign w_pop       = out_valid & out_ready;
    assign w_occ_after = w_usedw - UW'(w_pop);
    assign w_space_ok  = (UW'(DEPTH) - w_occ_after) >= UW'(FRAME_WORDS);

    always_comb begin
        w_header                      = '0;
        w_header[DATA_W-1 -: 4]       = HDR_TAG;
        w_header[15:8]                = 8'(r_chan);
        w_header[7:0]                 = r_seq;
    end

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    logic [DATA_W-1:0] r_ts;
    logic [DATA_W-1:0] r_stamp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts    <= '0;
            r_stamp <= '0;
        end else begin
            r_ts <= r_ts + DATA_W'(1);
            if (r_state == ST_HEADER)
                r_stamp <= r_ts;
        end
    end
`endif

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        case (r_state)
            ST_HEADER: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_header;
            end
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
            ST_STAMP: begin
                w_wr_en   = 1'b1;
                w_wr_data = r_stamp;
            end
`endif
            ST_SAMPLE: begin
                w_wr_en   = w_take;
                w_wr_data = w_sample;
            end
            ST_TRAILER: begin
                w_wr_en   = 1'b1;
                w_wr_data = TRAILER_WORD[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_mode            <= MODE_OFF;
            r_chan            <= '0;
            r_seq             <= '0;
            r_cnt             <= '0;
            r_first           <= 1'b0;
            r_last            <= '0;
            r_deferring       <= 1'b0;
            r_frames_deferred <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_mode == MODE_CONTINUOUS || cfg_mode == MODE_ON_CHANGE ||
                        (cfg_mode == MODE_SINGLE && arm))
                        r_state <= ST_WAIT_SPACE;
                end
                ST_WAIT_SPACE: begin
                    if (w_space_ok) begin
                        r_state     <= ST_HEADER;
                        r_mode      <= cfg_mode;
                        r_chan      <= cfg_chan;
                        r_deferring <= 1'b0;
                    end else begin
                        // Count each blocked frame once, not every stalled cycle.
                        r_deferring <= 1'b1;
                        if (!r_deferring && r_frames_deferred != 16'hFFFF)
                            r_frames_deferred <= r_frames_deferred + 16'd1;
                    end
                end
                ST_HEADER: begin
                    r_first <= 1'b1;
                    r_cnt   <= '0;
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
                    r_state <= ST_STAMP;
`else
                    r_state <= ST_SAMPLE;
`endif
                end
                ST_STAMP: r_state <= ST_SAMPLE;
                ST_SAMPLE: begin
                    if (w_take) begin
                        r_last  <= w_sample;
                        r_first <= 1'b0;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(FRAME_LEN - 1))
                            r_state <= ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    r_seq <= r_seq + 8'd1;
                    if (r_mode == MODE_SINGLE || cfg_mode == MODE_OFF)
                        r_state <= ST_IDLE;
                    else
                        r_state <= ST_WAIT_SPACE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    debug_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr_en),
        .wr_data  (w_wr_data),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .usedw    (w_usedw)
    );

    assign busy            = (r_state != ST_IDLE);
    assign frames_deferred = r_frames_deferred;

endmodule

// File: tb/tb_debug_capture.sv
// tb/tb_debug_capture.sv - directed self-checking bench for debug_capture
module tb_debug_capture;

    localparam int DATA_W    = 32;
    localparam int N_CH      = 4;
    localparam int FRAME_LEN = 512;
    localparam int DEPTH     = 1024;
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    localparam int TSW = 1;
`else
    localparam int TSW = 0;
`endif
    localparam int FW = FRAME_LEN + 2 + TSW;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [1:0]             cfg_mode = 2'd3;
    logic [1:0]             cfg_chan = 2'd0;
    logic                   arm = 1'b0;
    logic [N_CH*DATA_W-1:0] debug_in;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   busy;
    logic [15:0]            frames_deferred;

    logic [31:0] cnt = 32'd0;
    logic        gen_run = 1'b0;
    logic [31:0] got[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] exp_hdr;
        logic [31:0] exp_first;
    } vec_t;
    vec_t vecs[4];

    debug_capture #(
        .DATA_W    (DATA_W),
        .N_CH      (N_CH),
        .FRAME_LEN (FRAME_LEN),
        .DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_mode        (cfg_mode),
        .cfg_chan        (cfg_chan),
        .arm             (arm),
        .debug_in        (debug_in),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .frames_deferred (frames_deferred)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N_CH; k++)
            debug_in[k*DATA_W +: DATA_W] = {4'(k) ^ 4'd2, cnt[27:0]};
    end

    always @(negedge clk) begin
        if (gen_run)
            cnt = cnt + 32'd1;
    end

    always @(negedge clk) begin
        if (reset)
            got.delete();
        else if (out_valid && out_ready)
            got.push_back(out_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return (i < got.size()) ? got[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic int seq_breaks(input int first, input int n);
        int b = 0;
        for (int i = first; i < first + n - 1; i++)
            if (word(i + 1) != word(i) + 32'd1)
                b++;
        return b;
    endfunction

    task automatic wait_words(input int n, input int budget, input string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_words"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [1:0] chan, input logic rdy);
        reset     = 1'b1;
        arm       = 1'b0;
        gen_run   = 1'b0;
        cnt       = 32'd0;
        cfg_mode  = mode;
        cfg_chan  = chan;
        out_ready = rdy;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int k;
        int reps;
        vecs[0] = '{2'd2, 32'hA000_0200, 32'h0000_0000};
        vecs[1] = '{2'd0, 32'hA000_0000, 32'h2000_0000};
        vecs[2] = '{2'd1, 32'hA000_0100, 32'h3000_0000};
        vecs[3] = '{2'd3, 32'hA000_0300, 32'h1000_0000};

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frames_deferred", 32'(frames_deferred), 32'd0);

        // Continuous capture on each channel; first sample lands on the 4th (5th with stamp) edge after release.
        for (int v = 0; v < 4; v++) begin
            do_reset(2'd0, vecs[v].chan, 1'b1);
            repeat (4 + TSW) @(posedge clk);
            #1 gen_run = 1'b1;
            wait_words(FW + 2, 3000, "cont");
            check($sformatf("cont%0d_header", v), word(0), vecs[v].exp_hdr);
            check($sformatf("cont%0d_first", v), word(1 + TSW), vecs[v].exp_first);
            check($sformatf("cont%0d_last", v), word(FRAME_LEN + TSW), vecs[v].exp_first + 32'd511);
            check($sformatf("cont%0d_trailer", v), word(FW - 1), 32'hFFFF_FFFF);
            check($sformatf("cont%0d_next_header", v), word(FW), vecs[v].exp_hdr + 32'd1);
            check($sformatf("cont%0d_seq_breaks", v), 32'(seq_breaks(1 + TSW, FRAME_LEN)), 32'd0);
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
            check($sformatf("cont%0d_stamp_delta", v), word(FW + 1) - word(1), 32'(FRAME_LEN + 4));
`endif
        end

        do_reset(2'd1, 2'd2, 1'b1);
        cnt = 32'd5;
        repeat (100) @(posedge clk);
        #1 gen_run = 1'b1;
        wait_words(FW, 2000, "chg");
        check("chg_s0", word(1 + TSW), 32'd5);
        check("chg_s1", word(2 + TSW), 32'd6);
        check("chg_s2", word(3 + TSW), 32'd7);
        reps = 0;
        for (int i = 1 + TSW; i < FRAME_LEN + TSW; i++)
            if (word(i + 1) == word(i))
                reps++;
        check("chg_repeats", 32'(reps), 32'd0);
        check("chg_trailer", word(FW - 1), 32'hFFFF_FFFF);

        do_reset(2'd2, 2'd2, 1'b1);
        gen_run = 1'b1;
        repeat (3) @(posedge clk);
        check("single_idle_busy", 32'(busy), 32'd0);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        repeat (50) @(posedge clk);
        check("single_busy", 32'(busy), 32'd1);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        k = 0;
        while (busy && k < 1500) begin
            @(posedge clk);
            k++;
        end
        check("single_done", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        check("single_words", 32'(got.size()), 32'(FW));
        check("single_header", word(0), 32'hA000_0200);
        check("single_trailer", word(FW - 1), 32'hFFFF_FFFF);
        check("single_seq_breaks", 32'(seq_breaks(1 + TSW, FRAME_LEN)), 32'd0);

        do_reset(2'd0, 2'd2, 1'b0);
        gen_run = 1'b1;
        repeat (700) @(posedge clk);
        @(negedge clk);
        check("bp_frames_deferred", 32'(frames_deferred), 32'd1);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", out_data, 32'hA000_0200);
        check("bp_nothing_read", 32'(got.size()), 32'd0);
        out_ready = 1'b1;
        wait_words(FW + 1, 2500, "bp");
        check("bp_header", word(0), 32'hA000_0200);
        check("bp_seq_breaks", 32'(seq_breaks(1 + TSW, FRAME_LEN)), 32'd0);
        check("bp_trailer", word(FW - 1), 32'hFFFF_FFFF);
        check("bp_next_header", word(FW), 32'hA000_0201);

        do_reset(2'd0, 2'd2, 1'b1);
        gen_run = 1'b1;
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_words(1, 50, "midrst");
        check("midrst_header", word(0), 32'hA000_0200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_capture.md
# debug_capture

Parametrised, multi-channel debug capture unit that samples one of `N_CH` internal debug buses and packs the samples into fixed-length, self-describing frames in an on-chip FIFO. It supports free-running, on-change and single-shot capture. Downstream logic drains the frames through a valid/ready stream, typically a pipe-out bridge. It sits beside the datapath under test, in the same clock domain.

## Interface
- `DATA_W`, 32: width of each debug channel and of output words; minimum 20.
- `N_CH`, 4: number of debug channels; 1..256.
- `FRAME_LEN`, 512: sample words per frame; 1..`DEPTH`-3.
- `DEPTH`, 4096: FIFO depth in words; power of two.
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_mode`  in  2  0=CONTINUOUS, 1=ON_CHANGE, 2=SINGLE, 3=OFF.
- `cfg_chan`  in  max(1,$clog2(N_CH))  channel to capture.
- `arm`  in  1  single-cycle pulse that starts one frame in SINGLE mode.
- `debug_in`  in  N_CH*DATA_W  concatenated channels; channel k is bits [k*DATA_W +: DATA_W].
- `out_data`  out  DATA_W  FIFO head word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word when both valid and ready are high.
- `busy`  out  1  high in any state other than IDLE.
- `frames_deferred`  out  16  saturating count of frame starts delayed for lack of FIFO space.

## Operation
- Frame layout:
  - header `{4'hA, zero pad, chan[7:0], seq[7:0]}`;
  - optional timestamp (see Configuration);
  - `FRAME_LEN` samples;
  - trailer, all ones.
- `seq` increments mod 256 per completed frame and resets to 0.
- `cfg_mode` and `cfg_chan` are latched on the IDLE/WAIT_SPACE→HEADER transition. They are constant for the rest of the frame.
- FSM states: IDLE, WAIT_SPACE, HEADER, STAMP, SAMPLE, TRAILER.
- IDLE:
  - CONTINUOUS or ON_CHANGE → WAIT_SPACE;
  - SINGLE with `arm` → WAIT_SPACE;
  - OFF → stay in IDLE.
- WAIT_SPACE:
  - if free space is at least the frame word count, go to HEADER;
  - otherwise stay, and increment `frames_deferred` once, on the first cycle of the wait.
- HEADER writes the header word. It then goes to STAMP if the timestamp is compiled in, else to SAMPLE.
- SAMPLE:
  - CONTINUOUS and SINGLE write the selected channel every cycle.
  - ON_CHANGE writes only when the channel differs from the last written sample. The first sample of each frame is always written.
  - Leave after `FRAME_LEN` writes.
- TRAILER writes all ones, then:
  - SINGLE → IDLE;
  - otherwise, if the live `cfg_mode` is OFF → IDLE, else → WAIT_SPACE.
- A `cfg_mode` change mid-frame does not abort the frame.
- The FIFO can never overflow, because space is reserved per frame. No write is ever dropped.
- `arm` outside IDLE, or outside SINGLE mode, is ignored.

## Timing
- At reset, `out_valid`=0, `out_data`=0, `busy`=0, `frames_deferred`=0, `seq`=0, FSM=IDLE, FIFO empty.
- A write in cycle N is visible as `out_valid`=1 at cycle N+2: one cycle for the registered write, one for the registered read port (show-ahead).
- Simultaneous read and write at full or empty is legal. The occupancy count stays exact.
- The free-space check uses occupancy after the current cycle's pop.
- Sample capture: the word written in SAMPLE cycle N is `debug_in` sampled at edge N. There is no extra input register.
- In CONTINUOUS mode with `out_ready` held high, a frame takes `FRAME_LEN`+2 (+1) cycles. There is exactly 1 WAIT_SPACE cycle between frames.
- Reset asserted mid-frame aborts immediately. The partial frame is discarded with the FIFO.

## Configuration
- `DEBUG_CAPTURE_TIMESTAMP_EN` defined:
  - a free-running `DATA_W`-bit cycle counter (reset 0, wraps) is included;
  - its value on the HEADER cycle is written as the word after the header;
  - the frame word count is `FRAME_LEN`+3.
- Undefined: no counter, STAMP is unreachable, and the frame word count is `FRAME_LEN`+2.

## Structure
- Shared package `debug_capture_pkg` holds:
  - the mode encoding constants;
  - the state enumeration;
  - `HDR_TAG`=4'hA;
  - the trailer constant.
- One sub-module, `debug_sync_fifo`:
  - single-clock, show-ahead, registered read port;
  - parameters `WIDTH` and `DEPTH`;
  - exposes `usedw` with `$clog2(DEPTH)+1` bits.

## Test plan
- CONTINUOUS, `N_CH`=4, `cfg_chan`=2, channel 2 counting from 0, `out_ready`=1 → first frame reads:
  - header `A000_0200`;
  - samples 0..511, consecutive;
  - trailer `FFFF_FFFF`;
  - the next header has seq=1.
- ON_CHANGE with the channel held constant at 5 for 100 cycles, then counting → frame begins 5, 6, 7…, with no repeated 5. Every sample differs from its predecessor.
- SINGLE: pulse `arm` → exactly one frame (514 words), then `busy`=0. A second `arm` while busy produces no additional frame.
- Backpressure: `out_ready`=0 and `DEPTH`=1024 → after 1 frame, WAIT_SPACE blocks. `frames_deferred`=1 and the FIFO holds 514 words with no corruption. Releasing ready resumes capture.
- Reset asserted mid-SAMPLE → `out_valid` drops within one cycle. After release, the first word out is a seq=0 header.
- With `DEBUG_CAPTURE_TIMESTAMP_EN` → word 1 of consecutive continuous frames differs by exactly `FRAME_LEN`+4.
